// File: rtl/ui_event_pkg.sv
// rtl/ui_event_pkg.sv - shared pin indices and constants for the ui event capture block
package ui_event_pkg;

   // status bit positions on uio_out
   localparam int ST_EMPTY = 4;
   localparam int ST_FULL  = 5;
   localparam int ST_OVF   = 6;
   localparam int ST_VALID = 7;

   // control bit positions on uio_in
   localparam int UIO_POP = 0;
   localparam int UIO_CLR = 1;

   // upper nibble of uio is always driven
   localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - small event FIFO with sticky overflow and synchronous clear
module event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             ovf_q;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == DEPTH_C);
   assign overflow = ovf_q;
   assign rdata    = empty ? '0 : mem[rd_ptr];

   // a pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees the slot
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // pointer, occupancy and overflow bookkeeping; clear wins over push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push & ~do_push) ovf_q <= 1'b1;
      end
   end

   // storage is not reset; entries are only visible while count is nonzero
   always_ff @(posedge clk) begin
      if (do_push & ~clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ui_event_capture.sv
// rtl/ui_event_capture.sv - synchronises ui_in and logs each change into a host-drained FIFO
module ui_event_capture
   import ui_event_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0] ui_sync  [SYNC_STAGES];
   logic [1:0] ctl_sync [SYNC_STAGES];
   logic [7:0] s_ui;
   logic       s_pop;
   logic       s_clr;
   logic [7:0] prev_ui;
   logic       pop_d;
   logic       push;
   logic       pop;
   logic       f_empty;
   logic       f_full;
   logic       f_ovf;
   logic       unused_uio;

   assign unused_uio = &{1'b0, uio_in[7:2]};

   // synchroniser chains for the monitored bus and the pop/clear controls; always running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            ui_sync[i]  <= '0;
            ctl_sync[i] <= '0;
         end
      end else begin
         ui_sync[0]  <= ui_in;
         ctl_sync[0] <= uio_in[1:0];
         for (int i = 1; i < SYNC_STAGES; i++) begin
            ui_sync[i]  <= ui_sync[i-1];
            ctl_sync[i] <= ctl_sync[i-1];
         end
      end
   end

   assign s_ui  = ui_sync[SYNC_STAGES-1];
   assign s_pop = ctl_sync[SYNC_STAGES-1][UIO_POP];
   assign s_clr = ctl_sync[SYNC_STAGES-1][UIO_CLR];

   // reference copies track even when disabled so enabling never produces a stale event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ui <= '0;
         pop_d   <= 1'b0;
      end else begin
         prev_ui <= s_ui;
         pop_d   <= s_pop;
      end
   end

   assign push = ena & (s_ui != prev_ui) & ~s_clr;
   assign pop  = ena & s_pop & ~pop_d & ~s_clr;

   event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .clear    (s_clr),
      .wdata    (s_ui),
      .rdata    (uo_out),
      .empty    (f_empty),
      .full     (f_full),
      .overflow (f_ovf)
   );

   // status nibble on the upper uio pins, lower nibble held at zero
   always_comb begin
      uio_out           = '0;
      uio_out[ST_EMPTY] = f_empty;
      uio_out[ST_FULL]  = f_full;
      uio_out[ST_OVF]   = f_ovf;
      uio_out[ST_VALID] = ~f_empty;
   end

   assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_ui_event_capture.sv
// tb/tb_ui_event_capture.sv - scoreboard bench for ui_event_capture
module tb_ui_event_capture;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   typedef struct {
      string      name;
      logic [7:0] uo;
      logic [7:0] st;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   int   checks = 0;
   int   passed = 0;
   bit   done   = 1'b0;

   ui_event_capture #(
      .DEPTH       (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: consume one expectation per falling edge and compare against the pins
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         cur = sb_q.pop_front();
         checks++;
         if (uo_out === cur.uo && uio_out === cur.st && uio_oe === 8'hF0)
            passed++;
         else
            $display("FAIL %s: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h uio_out=%h uio_oe=f0",
                     cur.name, uo_out, uio_out, uio_oe, cur.uo, cur.st);
      end
   end

   // watchdog: the stimulus must complete within a bounded time
   initial begin
      #200000;
      if (!done) begin
         checks++;
         $display("FAIL watchdog: wait expired before the bench completed (%0d/%0d passed)", passed, checks);
         $finish;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_now(input string name, input logic [7:0] uo, input logic [7:0] st);
      checks++;
      if (uo_out === uo && uio_out === st && uio_oe === 8'hF0)
         passed++;
      else
         $display("FAIL %s: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h uio_out=%h uio_oe=f0",
                  name, uo_out, uio_out, uio_oe, uo, st);
   endtask

   task automatic expect_out(input string name, input logic [7:0] uo, input logic [7:0] st);
      exp_t e;
      e.name = name;
      e.uo   = uo;
      e.st   = st;
      sb_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic do_pop();
      uio_in[0] = 1'b1;
      tick(4);
      uio_in[0] = 1'b0;
      tick(4);
   endtask

   task automatic do_clear();
      uio_in[1] = 1'b1;
      tick(4);
      uio_in[1] = 1'b0;
      tick(4);
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      check_now("reset_direct", 8'h00, 8'h10);
      expect_out("reset", 8'h00, 8'h10);

      ena = 1'b1;
      tick(20);
      expect_out("idle_const", 8'h00, 8'h10);

      // write and drain, push latency of three edges
      ui_in = 8'h01;
      tick(2);
      expect_out("lat_after_2_edges", 8'h00, 8'h10);
      expect_out("lat_after_3_edges", 8'h01, 8'h80);
      tick(2);
      ui_in = 8'hA5;
      tick(5);
      ui_in = 8'h3C;
      tick(5);
      expect_out("drain_head_01", 8'h01, 8'h80);
      do_pop();
      expect_out("drain_head_a5", 8'hA5, 8'h80);
      do_pop();
      expect_out("drain_head_3c", 8'h3C, 8'h80);
      do_pop();
      expect_out("drain_empty", 8'h00, 8'h10);
      do_pop();
      expect_out("pop_on_empty", 8'h00, 8'h10);

      // nine changes into an eight-entry FIFO
      for (int i = 0; i < 9; i++) begin
         ui_in = 8'h10 + 8'(i);
         tick(3);
      end
      expect_out("fill_full_ovf", 8'h10, 8'hE0);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) expect_out($sformatf("ovf_drain_%0d", i), 8'h10 + 8'(i), 8'hC0);
         do_pop();
      end
      expect_out("ovf_sticky_empty", 8'h00, 8'h50);
      do_clear();
      expect_out("ovf_cleared", 8'h00, 8'h10);

      // full FIFO with pop and change on the same sync cycle
      for (int i = 0; i < 8; i++) begin
         ui_in = 8'h20 + 8'(i);
         tick(3);
      end
      expect_out("full_no_ovf", 8'h20, 8'hA0);
      ui_in     = 8'h28;
      uio_in[0] = 1'b1;
      tick(4);
      uio_in[0] = 1'b0;
      tick(4);
      expect_out("simul_full", 8'h21, 8'hA0);
      for (int i = 0; i < 7; i++) do_pop();
      expect_out("simul_last_new", 8'h28, 8'h80);
      do_pop();
      expect_out("simul_drained", 8'h00, 8'h10);

      // clear beats an in-flight change and pop
      for (int i = 0; i < 9; i++) begin
         ui_in = 8'h30 + 8'(i);
         tick(3);
      end
      expect_out("clr_pre_full", 8'h30, 8'hE0);
      ui_in  = 8'h40;
      uio_in = 8'h03;
      tick(4);
      uio_in = 8'h00;
      tick(4);
      expect_out("clr_priority", 8'h00, 8'h10);
      tick(4);
      expect_out("clr_no_late_event", 8'h00, 8'h10);

      // disabled: no push, no pop; enabling makes no stale event
      ena   = 1'b0;
      ui_in = 8'h00;
      tick(4);
      ui_in = 8'h55;
      do_pop();
      expect_out("disabled_no_entry", 8'h00, 8'h10);
      ena = 1'b1;
      tick(5);
      expect_out("enable_no_stale", 8'h00, 8'h10);

      // asynchronous reset mid-fill
      ui_in = 8'h60;
      tick(4);
      ui_in = 8'h61;
      tick(4);
      expect_out("prefill_head", 8'h60, 8'h80);
      tick(1);
      rst_n = 1'b0;
      #1;
      check_now("async_reset_direct", 8'h00, 8'h10);
      expect_out("async_reset", 8'h00, 8'h10);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      expect_out("first_event_after_reset", 8'h61, 8'h80);

      tick(2);
      done = 1'b1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
